// File: rtl/cordic_pkg.sv
// Shared types and constants for the CORDIC angle front end and its multiplier.
package cordic_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    MUL    = 3'd1,
    LAUNCH = 3'd2,
    BUSY   = 3'd3,
    DONE   = 3'd4
  } state_e;

  localparam logic [1:0] Q0 = 2'b00;
  localparam logic [1:0] Q1 = 2'b01;
  localparam logic [1:0] Q2 = 2'b10;
  localparam logic [1:0] Q3 = 2'b11;

  // pi/2 scaled by 2^62; narrower widths are rounded to nearest from this
  localparam logic [63:0] PI_HALF_Q62 = 64'h6487ED5110B4611A;

  function automatic logic [63:0] pi_half(input int ow);
    logic [63:0] rnd;
    rnd = 64'd1 << (63 - ow);
    return (PI_HALF_Q62 + rnd) >> (64 - ow);
  endfunction

  localparam logic [63:0] PI_HALF_32W = pi_half(32);
  localparam logic [31:0] PI_HALF     = PI_HALF_32W[31:0];

endpackage

// File: rtl/cordic_angle_frontend_if.sv
// Request, CORDIC-controller and response signals of the angle front end.
interface cordic_angle_frontend_if #(
  parameter int W  = 16,
  parameter int OW = 32
);
  logic          req_valid;
  logic          req_ready;
  logic [W-1:0]  req_angle;
  logic          req_operation;
  logic          beg_FSM_CORDIC;
  logic          operation;
  logic [1:0]    shift_region_flag;
  logic [OW-1:0] z0_angle;
  logic          ready_CORDIC;
  logic          ACK_FSM_CORDIC;
  logic          rsp_valid;
  logic          rsp_ack;

  modport slave (
    input  req_valid, req_angle, req_operation, ready_CORDIC, rsp_ack,
    output req_ready, beg_FSM_CORDIC, operation, shift_region_flag, z0_angle,
           ACK_FSM_CORDIC, rsp_valid
  );

  modport master (
    output req_valid, req_angle, req_operation, ready_CORDIC, rsp_ack,
    input  req_ready, beg_FSM_CORDIC, operation, shift_region_flag, z0_angle,
           ACK_FSM_CORDIC, rsp_valid
  );
endinterface

// File: rtl/cordic_seq_mult.sv
// Shift-add multiplier: product = floor(a * b / 2^N), a taken as an unsigned N-bit fraction.
// Loads on start, consumes one bit of a per cycle LSB first; done pulses in the Nth cycle with product valid.
module cordic_seq_mult #(
  parameter int N = 14,
  parameter int M = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [M-1:0] b,
  output logic         busy,
  output logic         done,
  output logic [M-1:0] product
);
  localparam int            CW   = (N > 1) ? $clog2(N) : 1;
  localparam int            PW   = N + M;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic          busy_q, busy_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  a_q, a_d;
  logic [PW-1:0] b_q, b_d;
  logic [PW-1:0] acc_q, acc_d;
  logic [PW-1:0] sum;

  always_comb begin
    sum     = acc_q + (a_q[0] ? b_q : '0);
    done    = busy_q && (cnt_q == LAST);
    // full-width sum is exact; only the integer part above the fraction is returned
    product = sum[PW-1:N];
    busy_d  = busy_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    if (start) begin
      busy_d = 1'b1;
      cnt_d  = '0;
      a_d    = a;
      b_d    = {{N{1'b0}}, b};
      acc_d  = '0;
    end else if (busy_q) begin
      acc_d = sum;
      a_d   = a_q >> 1;
      b_d   = b_q << 1;
      cnt_d = cnt_q + CW'(1);
      if (done) begin
        busy_d = 1'b0;
      end
    end
  end

  assign busy = busy_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      a_q    <= '0;
      b_q    <= '0;
      acc_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      a_q    <= a_d;
      b_q    <= b_d;
      acc_q  <= acc_d;
    end
  end

endmodule

// File: rtl/cordic_angle_frontend.sv
// Splits a binary angle into quadrant and residual, scales the residual by pi/2 and launches the CORDIC run.
// Start pulse W-1 cycles after accept; one request in flight, req_ready only in IDLE, results held until rsp_ack.
module cordic_angle_frontend #(
  parameter int W  = 16,
  parameter int OW = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  cordic_angle_frontend_if.slave bus
);
  import cordic_pkg::*;

  localparam int            RW         = W - 2;
  localparam logic [63:0]   PI_HALF_W  = pi_half(OW);
  localparam logic [OW-1:0] PI_HALF_OW = PI_HALF_W[OW-1:0];

  state_e        state_q, state_d;
  logic          op_q, op_d;
  logic [1:0]    flag_q, flag_d;
  logic [OW-1:0] z0_q, z0_d;
  logic          mult_start;
  logic          mult_busy;
  logic          mult_done;
  logic [OW-1:0] mult_product;

  cordic_seq_mult #(
    .N (RW),
    .M (OW)
  ) u_mult (
    .clk     (clk),
    .reset   (reset),
    .start   (mult_start),
    .a       (bus.req_angle[RW-1:0]),
    .b       (PI_HALF_OW),
    .busy    (mult_busy),
    .done    (mult_done),
    .product (mult_product)
  );

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    flag_d     = flag_q;
    z0_d       = z0_q;
    mult_start = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          op_d       = bus.req_operation;
          flag_d     = bus.req_angle[W-1:W-2];
          mult_start = 1'b1;
          state_d    = MUL;
        end
      end
      MUL: begin
        // a multiplier that is not running here can never finish; recover rather than hang
        if (!mult_busy) begin
          state_d = IDLE;
        end else if (mult_done) begin
          z0_d    = mult_product;
          state_d = LAUNCH;
        end
      end
      LAUNCH: state_d = BUSY;
      BUSY: begin
        if (bus.ready_CORDIC) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.rsp_ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= 1'b0;
      flag_q  <= Q0;
      z0_q    <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      flag_q  <= flag_d;
      z0_q    <= z0_d;
    end
  end

  assign bus.req_ready         = (state_q == IDLE);
  assign bus.beg_FSM_CORDIC    = (state_q == LAUNCH);
  assign bus.rsp_valid         = (state_q == DONE);
  assign bus.ACK_FSM_CORDIC    = (state_q == DONE) && bus.rsp_ack;
  assign bus.operation         = op_q;
  assign bus.shift_region_flag = flag_q;
  assign bus.z0_angle          = z0_q;

endmodule

// File: tb/tb_cordic_angle_frontend.sv
// Scoreboard bench: the driver queues expected results from an arithmetic model, a negedge monitor checks
// launch timing, latched values, handshakes and stability; CORDIC controller and consumer are modelled by responders.
module tb_cordic_angle_frontend;
  localparam int              W           = 16;
  localparam int              OW          = 32;
  localparam int              RW          = W - 2;
  localparam int              LAUNCH_DLY  = W - 1;
  localparam longint unsigned PI_HALF_REF = 64'd1686629713;

  typedef struct {
    logic          op;
    logic [1:0]    flag;
    logic [OW-1:0] z0;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  cordic_angle_frontend_if #(.W(W), .OW(OW)) bus ();

  cordic_angle_frontend #(.W(W), .OW(OW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int   checks    = 0;
  int   failures  = 0;
  int   cyc       = 0;
  int   rdy_delay = 20;
  int   ack_delay = 5;
  bit   noise     = 1'b0;
  exp_t sb[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // quadrant = angle / quarter-turn, z0 = (angle mod quarter-turn) * pi/2 / quarter-turn, truncated
  function automatic exp_t model(input logic [W-1:0] ang, input logic op);
    exp_t            e;
    longint unsigned quarter;
    longint unsigned resid;
    quarter = longint'(1) << RW;
    resid   = longint'(ang) % quarter;
    e.op    = op;
    e.flag  = 2'(longint'(ang) / quarter);
    e.z0    = OW'((resid * PI_HALF_REF) / quarter);
    return e;
  endfunction

  // monitor: models the request timeline from what has been accepted and checks every cycle
  bit   txn     = 1'b0;
  int   acc_cyc = 0;
  int   rdy_cyc = -1;
  exp_t cur;

  always @(negedge clk) begin
    int d;
    bit rv_exp;
    if (reset) begin
      txn     = 1'b0;
      rdy_cyc = -1;
    end else if (!txn) begin
      chk("req_ready_idle", bus.req_ready, 1);
      chk("beg_idle", bus.beg_FSM_CORDIC, 0);
      chk("rsp_valid_idle", bus.rsp_valid, 0);
      chk("ack_idle", bus.ACK_FSM_CORDIC, 0);
      if (bus.req_valid) begin
        txn     = 1'b1;
        acc_cyc = cyc;
        rdy_cyc = -1;
      end
    end else begin
      d      = cyc - acc_cyc;
      rv_exp = (rdy_cyc >= 0);
      chk("req_ready_busy", bus.req_ready, 0);
      chk("beg_timing", bus.beg_FSM_CORDIC, d == LAUNCH_DLY);
      if (d == LAUNCH_DLY) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL sb_underflow: got a launch, expected no pending request (cycle %0d)", cyc);
        end else begin
          cur = sb.pop_front();
          chk("operation", bus.operation, cur.op);
          chk("shift_region_flag", bus.shift_region_flag, cur.flag);
          chk("z0_angle", bus.z0_angle, cur.z0);
        end
      end else if (d > LAUNCH_DLY) begin
        chk("operation_stable", bus.operation, cur.op);
        chk("flag_stable", bus.shift_region_flag, cur.flag);
        chk("z0_stable", bus.z0_angle, cur.z0);
      end
      chk("rsp_valid", bus.rsp_valid, rv_exp);
      chk("ack_relay", bus.ACK_FSM_CORDIC, rv_exp && bus.rsp_ack);
      if (rv_exp && bus.rsp_ack) begin
        txn = 1'b0;
      end else if (!rv_exp && d > LAUNCH_DLY && bus.ready_CORDIC) begin
        rdy_cyc = cyc;
      end
    end
  end

  // CORDIC controller: ready rdy_delay cycles after the start pulse, held until the front end returns to idle
  initial begin : cordic_model
    int rc;
    rc = -1;
    bus.ready_CORDIC = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        rc = -1;
        bus.ready_CORDIC = 1'b0;
      end else if (bus.beg_FSM_CORDIC) begin
        rc = rdy_delay;
        bus.ready_CORDIC = (rc == 0) ? 1'b1 : (noise & 1'($urandom));
      end else if (rc > 0) begin
        rc--;
        bus.ready_CORDIC = (rc == 0);
      end else if (rc == 0 && !bus.req_ready) begin
        bus.ready_CORDIC = 1'b1;
      end else begin
        rc = -1;
        bus.ready_CORDIC = noise & 1'($urandom);
      end
    end
  end

  // consumer: holds rsp_ack low for ack_delay cycles of rsp_valid, optional stray acks elsewhere
  initial begin : consumer
    int wc;
    wc = -1;
    bus.rsp_ack = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        wc = -1;
        bus.rsp_ack = 1'b0;
      end else if (bus.rsp_valid) begin
        if (wc < 0) wc = ack_delay;
        if (wc == 0) begin
          bus.rsp_ack = 1'b1;
        end else begin
          bus.rsp_ack = 1'b0;
          wc--;
        end
      end else begin
        wc = -1;
        bus.rsp_ack = noise & 1'($urandom);
      end
    end
  end

  task automatic send(input logic [W-1:0] ang, input logic op);
    int n;
    n = 0;
    sb.push_back(model(ang, op));
    bus.req_valid     = 1'b1;
    bus.req_angle     = ang;
    bus.req_operation = op;
    @(negedge clk);
    while (!bus.req_ready && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout: req_ready got 0, expected 1 within 3000 cycles");
    end
    @(posedge clk);
    #1;
    bus.req_valid     = 1'b0;
    bus.req_angle     = W'($urandom);
    bus.req_operation = 1'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(posedge clk);
      #2;
      n++;
    end while (!(bus.req_ready && sb.size() == 0) && n < 3000);
    if (n >= 3000) begin
      checks++;
      failures++;
      $display("FAIL idle_timeout: pending=%0d req_ready=%0b, expected 0 and 1", sb.size(), bus.req_ready);
    end
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_req_ready"}, bus.req_ready, 1);
    chk({tag, "_beg"}, bus.beg_FSM_CORDIC, 0);
    chk({tag, "_operation"}, bus.operation, 0);
    chk({tag, "_flag"}, bus.shift_region_flag, 0);
    chk({tag, "_z0"}, bus.z0_angle, 0);
    chk({tag, "_rsp_valid"}, bus.rsp_valid, 0);
    chk({tag, "_ack"}, bus.ACK_FSM_CORDIC, 0);
  endtask

  task automatic pulse_reset(input string tag);
    @(posedge clk);
    #1;
    reset         = 1'b1;
    bus.req_valid = 1'b0;
    sb.delete();
    @(posedge clk);
    @(negedge clk);
    check_reset_state(tag);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin : main
    int n;
    logic [W-1:0] ang;
    bus.req_valid     = 1'b0;
    bus.req_angle     = '0;
    bus.req_operation = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_state("por");
    @(posedge clk);
    #1;
    reset = 1'b0;

    send(16'h4000, 1'b0);
    wait_idle();
    send(16'h2000, 1'b1);
    wait_idle();
    send(16'hFFFF, 1'($urandom));
    wait_idle();

    noise     = 1'b1;
    rdy_delay = 0;
    ack_delay = 0;
    send(16'hC000, 1'b1);
    send(16'h8001, 1'b0);
    send(16'h3FFF, 1'b1);
    wait_idle();

    for (int i = 0; i < 30; i++) begin
      rdy_delay = $urandom_range(0, 25);
      ack_delay = $urandom_range(0, 6);
      ang       = W'($urandom);
      if ($urandom_range(0, 4) == 0) ang[RW-1:0] = '0;
      send(ang, 1'($urandom));
      if ($urandom_range(0, 1) == 1) wait_idle();
    end
    wait_idle();

    rdy_delay = 5;
    send(W'($urandom), 1'b1);
    repeat (4) @(posedge clk);
    pulse_reset("mid_mul");
    send(16'h2000, 1'b0);
    wait_idle();

    rdy_delay = 60;
    send(16'hA123, 1'b1);
    n = 0;
    while (!bus.beg_FSM_CORDIC && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      checks++;
      failures++;
      $display("FAIL launch_timeout: beg_FSM_CORDIC got 0, expected 1 within 100 cycles");
    end
    repeat (3) @(posedge clk);
    pulse_reset("mid_busy");
    rdy_delay = 3;
    send(16'h6000, 1'b1);
    wait_idle();

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
